// File: rtl/shift_arb_seq_pkg.sv
// Shared types for the shift arbiter/sequencer: operation codes, sequencer
// states and a small helper that classifies an operation.
package shift_arb_seq_pkg;

    // Operation codes on op0/op1. Bit 0 is the first-pass direction
    // (1 = left), and bit 1 marks a rotate.
    typedef enum logic [1:0] {
        SHOP_SRL = 2'b00,
        SHOP_SLL = 2'b01,
        SHOP_ROR = 2'b10,
        SHOP_ROL = 2'b11
    } shOp_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PASS1 = 2'b01,
        ST_PASS2 = 2'b10,
        ST_DONE  = 2'b11
    } seqState_t;

    // A rotate uses two shifter passes whose results are OR'd together.
    function automatic logic isRotate(input shOp_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/shift_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins. On a tie, the
// requester that did not win last time wins. The grant is one-hot or zero.
module shift_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Pass single requests straight through; break ties against the last winner.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/shift_arb_seq.sv
// Shares one combinational barrel shifter between two requesters. Picks a
// winner round-robin, latches its operands, and drives the shifter for one
// pass (logical shifts) or two OR'd passes (rotates). The result then comes
// back with a one-cycle done pulse.
//
// Handshake: reqN is a level that is sampled only in IDLE. gntN pulses for
// the one cycle after the operands were latched, and the requester drops reqN
// from then on. A reqN still high in IDLE is a new request. doneN pulses for
// one cycle while res holds the result for requester N.
module shift_arb_seq
    import shift_arb_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] s0,
    input  logic [DATA_WIDTH-1:0] s1,
    input  logic [1:0]            op0,
    input  logic [1:0]            op1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] res,
    output logic [DATA_WIDTH-1:0] sh_d,
    output logic [DATA_WIDTH-1:0] sh_s,
    output logic                  sh_lnr,
    input  logic [DATA_WIDTH-1:0] sh_y,
    output seqState_t             dbgState
);

    seqState_t             state;
    seqState_t             stateNext;
    logic                  lastGrant;
    logic                  owner;
    logic [DATA_WIDTH-1:0] dReg;
    logic [DATA_WIDTH-1:0] sReg;
    shOp_t                 opReg;
    logic [1:0]            grant;
    logic [SHAMT_WIDTH-1:0] rotAmt;
    logic                  needPass2;

    // The rotate amount is the shift amount modulo DATA_WIDTH. A rotate by
    // zero finishes after the first pass.
    assign rotAmt    = sReg[SHAMT_WIDTH-1:0];
    assign needPass2 = isRotate(opReg) && (rotAmt != '0);
    assign dbgState  = state;

    shift_rr_arb2 uArb (
        .req   ({req1, req0}),
        .last  (lastGrant),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: IDLE -> PASS1 -> [PASS2] -> DONE -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (grant != 2'b00) stateNext = ST_PASS1;
            ST_PASS1: stateNext = needPass2 ? ST_PASS2 : ST_DONE;
            ST_PASS2: stateNext = ST_DONE;
            ST_DONE:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Operand latches, round-robin history, grant pulse and result register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            dReg      <= '0;
            sReg      <= '0;
            opReg     <= SHOP_SRL;
            res       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner     <= grant[1];
                        lastGrant <= grant[1];
                        dReg      <= grant[1] ? d1 : d0;
                        sReg      <= grant[1] ? s1 : s0;
                        opReg     <= shOp_t'(grant[1] ? op1 : op0);
                        gnt0      <= grant[0];
                        gnt1      <= grant[1];
                    end
                end
                ST_PASS1: res <= (isRotate(opReg) && (rotAmt == '0)) ? dReg : sh_y;
                ST_PASS2: res <= res | sh_y;
                default: ;
            endcase
        end
    end

    // Shifter drive and done pulse. The shifter inputs stay at zero outside
    // the two pass states.
    always_comb begin
        done0  = 1'b0;
        done1  = 1'b0;
        sh_d   = '0;
        sh_s   = '0;
        sh_lnr = 1'b0;
        case (state)
            ST_PASS1: begin
                sh_d   = dReg;
                sh_s   = isRotate(opReg) ? DATA_WIDTH'(rotAmt) : sReg;
                sh_lnr = opReg[0];
            end
            ST_PASS2: begin
                sh_d   = dReg;
                sh_s   = DATA_WIDTH'(DATA_WIDTH) - DATA_WIDTH'(rotAmt);
                sh_lnr = ~opReg[0];
            end
            ST_DONE: begin
                done0 = ~owner;
                done1 = owner;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_arb_seq.sv
// Directed and randomised bench for shift_arb_seq. It includes a behavioural
// barrel shifter and a queue of expected results.
module tb_shift_arb_seq;
    import shift_arb_seq_pkg::*;

    logic        CLK;
    logic        RST;
    logic        req0, req1;
    logic [31:0] d0, d1, s0, s1;
    logic [1:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] res, sh_d, sh_s, sh_y;
    logic        sh_lnr;
    seqState_t   dbgState;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        expOwner_q[$];
    logic        expGnt_q[$];

    // Behavioural barrel shifter. A shift by 32 or more gives zero.
    assign sh_y = sh_lnr ? (sh_d << sh_s) : (sh_d >> sh_s);

    shift_arb_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1),
        .d0(d0), .d1(d1), .s0(s0), .s1(s1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .sh_d(sh_d), .sh_s(sh_s), .sh_lnr(sh_lnr), .sh_y(sh_y),
        .dbgState(dbgState)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference result, computed directly rather than in two passes.
    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [31:0] s,
                                             input logic [1:0] op);
        logic [5:0] k;
        k = {1'b0, s[4:0]};
        case (op)
            2'b00:   return d >> s;
            2'b01:   return d << s;
            2'b10:   return (d >> k) | (d << (6'd32 - k));
            default: return (d << k) | (d >> (6'd32 - k));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    // Advance one cycle and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one single-requester transaction. The call starts in an IDLE cycle
    // (cycle 0) and returns in the IDLE cycle that follows DONE.
    task automatic runOne(input logic who, input logic [31:0] d, input logic [31:0] s,
                          input logic [1:0] op, input logic [31:0] expRes,
                          input int expLat, input string tag);
        int   cyc;
        logic got;
        if (who) begin req1 = 1'b1; d1 = d; s1 = s; op1 = op; end
        else     begin req0 = 1'b1; d0 = d; s0 = s; op0 = op; end
        exp_q.push_back(expRes);
        expOwner_q.push_back(who);
        step();
        check({tag, " gnt"}, {30'b0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
        check({tag, " p1 sh_d"}, sh_d, d);
        check({tag, " p1 sh_s"}, sh_s, op[1] ? {27'b0, s[4:0]} : s);
        check({tag, " p1 sh_lnr"}, {31'b0, sh_lnr}, {31'b0, op[0]});
        // Drop the request and scramble the operands.
        req0 = 1'b0; req1 = 1'b0;
        d0 = $urandom; d1 = $urandom; s0 = $urandom; s1 = $urandom;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 8) begin
            step();
            cyc++;
            if (cyc == 2 && expLat == 3) begin
                check({tag, " p2 sh_s"}, sh_s, 32'd32 - {27'b0, s[4:0]});
                check({tag, " p2 sh_lnr"}, {31'b0, sh_lnr}, {31'b0, ~op[0]});
            end
            if (done0 | done1) begin
                got = 1'b1;
                check({tag, " done owner"}, {31'b0, done1}, {31'b0, expOwner_q.pop_front()});
                check({tag, " latency"}, cyc, expLat);
                check({tag, " res"}, res, exp_q.pop_front());
            end
        end
        check({tag, " done seen"}, {31'b0, got}, 32'd1);
        step();
        check({tag, " back idle"}, {30'b0, dbgState}, {30'b0, ST_IDLE});
        check({tag, " idle sh_s"}, sh_s, 32'd0);
    endtask

    initial begin : stim
        int          nDone;
        int          gntSeen;
        logic [1:0]  rop;
        logic [31:0] rd, rs;
        logic        rwho;

        RST = 1'b0; req0 = 1'b1; req1 = 1'b0;
        d0 = 32'h5; d1 = '0; s0 = 32'd6; s1 = '0; op0 = 2'b01; op1 = 2'b00;

        // Reset held with a request pending.
        repeat (2) begin
            step();
            check("rst gnt", {30'b0, gnt1, gnt0}, 32'd0);
            check("rst done", {30'b0, done1, done0}, 32'd0);
            check("rst res", res, 32'd0);
            check("rst sh_d", sh_d, 32'd0);
            check("rst sh_s", sh_s, 32'd0);
            check("rst sh_lnr", {31'b0, sh_lnr}, 32'd0);
            check("rst state", {30'b0, dbgState}, {30'b0, ST_IDLE});
        end
        req0 = 1'b0;
        RST  = 1'b1;
        step();

        // Directed single transactions.
        runOne(1'b0, 32'h5,  32'd6,  2'b01, 32'h0000_0140, 2, "sll");
        runOne(1'b0, 32'h15, 32'd47, 2'b00, 32'h0000_0000, 2, "srl47");
        runOne(1'b0, 32'hA5, 32'd32, 2'b11, 32'h0000_00A5, 2, "rol_k0");
        runOne(1'b1, 32'h15, 32'd8,  2'b10, 32'h1500_0000, 3, "ror8");

        // Both requesters held high. The last winner was 1, so the order is 0,1,0.
        req0 = 1'b1; d0 = 32'h1234;      s0 = 32'd4; op0 = 2'b01;
        req1 = 1'b1; d1 = 32'hF000_0000; s1 = 32'd8; op1 = 2'b11;
        exp_q.push_back(32'h0001_2340); expOwner_q.push_back(1'b0); expGnt_q.push_back(1'b0);
        exp_q.push_back(32'h0000_00F0); expOwner_q.push_back(1'b1); expGnt_q.push_back(1'b1);
        exp_q.push_back(32'h0001_2340); expOwner_q.push_back(1'b0); expGnt_q.push_back(1'b0);
        nDone = 0;
        gntSeen = 0;
        for (int c = 0; c < 40 && nDone < 3; c++) begin
            step();
            check("tie gnt overlap", {31'b0, gnt0 & gnt1}, 32'd0);
            check("tie done overlap", {31'b0, done0 & done1}, 32'd0);
            if ((gnt0 | gnt1) && expGnt_q.size() > 0) begin
                gntSeen++;
                check("tie gnt order", {31'b0, gnt1}, {31'b0, expGnt_q.pop_front()});
            end
            if ((done0 | done1) && exp_q.size() > 0) begin
                nDone++;
                check("tie done owner", {31'b0, done1}, {31'b0, expOwner_q.pop_front()});
                check("tie res", res, exp_q.pop_front());
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie done count", nDone, 3);
        check("tie gnt count", gntSeen, 3);
        step();
        check("tie back idle", {30'b0, dbgState}, {30'b0, ST_IDLE});

        // Reset during PASS2 of a rotate abandons it.
        req0 = 1'b1; d0 = 32'h8000_0001; s0 = 32'd4; op0 = 2'b11;
        step();
        check("abort gnt0", {31'b0, gnt0}, 32'd1);
        req0 = 1'b0;
        step();
        check("abort in pass2", {30'b0, dbgState}, {30'b0, ST_PASS2});
        RST = 1'b0;
        step();
        check("abort state", {30'b0, dbgState}, {30'b0, ST_IDLE});
        check("abort done", {30'b0, done1, done0}, 32'd0);
        check("abort res", res, 32'd0);
        RST = 1'b1;
        step();
        check("abort no late done", {30'b0, done1, done0}, 32'd0);
        runOne(1'b0, 32'h1, 32'd31, 2'b01, 32'h8000_0000, 2, "sll31");

        // Randomised transactions checked against the reference shifter.
        for (int i = 0; i < 8; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rd   = $urandom;
            rs   = 32'($urandom_range(0, 40));
            rwho = 1'($urandom_range(0, 1));
            runOne(rwho, rd, rs, rop, refShift(rd, rs, rop),
                   (rop[1] && rs[4:0] != 5'd0) ? 3 : 2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
